div: RTL and testbench

- Multi-cycle iterative integer divider serving the EX stage's DIV/DIVU instructions.
- EX drives the operands and the start signed/unsigned request, and holds start while it stalls the pipeline.
- This block runs a restoring shift-subtract loop, one quotient bit per cycle, and returns {remainder, quotient}.
- EX writes the remainder to HI and the quotient to LO.

---
 rtl/div_if.sv | 22 ++
 rtl/div.sv | 119 +++++++++++
 tb/tb_div.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Operand/result bundle between the EX stage (master) and the iterative divider (slave).
interface div_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// result is {remainder, quotient} with sign fix-up applied for signed operations.
module div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t                     state, state_nxt;
  logic        [CNT_W-1:0]    cnt_p0;
  logic        [DATA_W-1:0]   dvd_p0;
  logic        [DATA_W-1:0]   dvs_p0;
  logic        [DATA_W-1:0]   rem_p0;
  logic                       sgn_mode_p0, sgn1_p0, sgn2_p0;
  logic signed [DATA_W:0]     diff;
  logic                       accept, step, done;
  logic                       ready_nxt;
  logic        [2*DATA_W-1:0] result_nxt;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + DATA_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic            sgn);
    return (sgn && v[DATA_W-1]) ? negate(v) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] fixup(input logic [DATA_W-1:0] q,
                                                input logic [DATA_W-1:0] r,
                                                input logic mode,
                                                input logic s1,
                                                input logic s2);
    logic [DATA_W-1:0] qf, rf;
    qf = (mode && (s1 ^ s2)) ? negate(q) : q;
    rf = (mode && s1) ? negate(r) : r;
    return {rf, qf};
  endfunction

  assign accept = (state == FREE) && bus.start_i && !bus.annul_i;
  assign done   = (state == ON) && (cnt_p0 == CNT_W'(DATA_W));
  assign step   = (state == ON) && !done;
  // Trial subtraction of the divisor from the shifted partial remainder; MSB set means it went negative.
  assign diff   = $signed({rem_p0, dvd_p0[DATA_W-1]}) - $signed({1'b0, dvs_p0});

  always_comb begin
    state_nxt  = state;
    ready_nxt  = 1'b0;
    result_nxt = '0;
    case (state)
      FREE: begin
        if (accept) state_nxt = (bus.opdata2_i == '0) ? BYZERO : ON;
      end
      BYZERO: begin
        if (bus.annul_i) begin
          state_nxt = FREE;
        end else begin
          state_nxt = END;
          ready_nxt = 1'b1;
        end
      end
      ON: begin
        if (bus.annul_i) begin
          state_nxt = FREE;
        end else if (done) begin
          state_nxt  = END;
          ready_nxt  = 1'b1;
          result_nxt = fixup(dvd_p0, rem_p0, sgn_mode_p0, sgn1_p0, sgn2_p0);
        end
      end
      END: begin
        if (!bus.start_i || bus.annul_i) begin
          state_nxt = FREE;
        end else begin
          ready_nxt  = 1'b1;
          result_nxt = bus.result_o;
        end
      end
      default: state_nxt = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FREE;
      cnt_p0       <= '0;
      bus.ready_o  <= 1'b0;
      bus.result_o <= '0;
    end else begin
      state        <= state_nxt;
      bus.ready_o  <= ready_nxt;
      bus.result_o <= result_nxt;
      if (accept)    cnt_p0 <= '0;
      else if (step) cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  // Datapath: capture magnitudes at accept, then shift quotient bits into the dividend register.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_p0      <= magnitude(bus.opdata1_i, bus.signed_div_i);
      dvs_p0      <= magnitude(bus.opdata2_i, bus.signed_div_i);
      rem_p0      <= '0;
      sgn_mode_p0 <= bus.signed_div_i;
      sgn1_p0     <= bus.opdata1_i[DATA_W-1];
      sgn2_p0     <= bus.opdata2_i[DATA_W-1];
    end else if (step) begin
      if (!diff[DATA_W]) rem_p0 <= diff[DATA_W-1:0];
      else               rem_p0 <= {rem_p0[DATA_W-2:0], dvd_p0[DATA_W-1]};
      dvd_p0 <= {dvd_p0[DATA_W-2:0], ~diff[DATA_W]};
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed-vector bench for the iterative divider: latency, results, annul, reset and END hold.
module tb_div;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  div_if #(.DATA_W(32)) bus ();

  div #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Edges are counted from the accept edge (edge 1); chg>0 corrupts the operand inputs after edge chg.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp, input int lat,
                         input int hold, input int chg);
    int n;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = sgn;
    bus.start_i      = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == chg) begin
        bus.opdata1_i    = 32'd99;
        bus.opdata2_i    = 32'd1;
        bus.signed_div_i = ~sgn;
      end
    end while (!bus.ready_o && n < 60);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_res"}, bus.result_o, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_rdy"}, 64'(bus.ready_o), 64'd1);
      check({tag, "_hold_res"}, bus.result_o, exp);
    end
    bus.start_i = 1'b0;
    tick();
    check({tag, "_drop_rdy"}, 64'(bus.ready_o), 64'd0);
    check({tag, "_drop_res"}, bus.result_o, 64'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.ready_o) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    tick();
    tick();
    check("reset_rdy", 64'(bus.ready_o), 64'd0);
    check("reset_res", bus.result_o, 64'd0);
    rst = 1'b0;
    tick();

    run_div("udiv_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 34, 0, 0);
    tick();
    run_div("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 0, 0);
    tick();
    run_div("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 34, 0, 0);
    tick();
    run_div("divzero", 32'h1234_5678, 32'd0, 1'b0, 64'd0, 2, 0, 0);
    tick();

    // Annul at step 10 of a long division.
    bus.opdata1_i    = 32'hFFFF_FFFF;
    bus.opdata2_i    = 32'd3;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    bus.annul_i = 1'b1;
    tick();
    check("annul_rdy", 64'(bus.ready_o), 64'd0);
    check("annul_res", bus.result_o, 64'd0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    quiet("annul_quiet", 40);
    run_div("after_annul_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 34, 0, 0);
    tick();

    // Reset at step 20.
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_rdy", 64'(bus.ready_o), 64'd0);
    check("rst_mid_res", bus.result_o, 64'd0);
    rst         = 1'b0;
    bus.start_i = 1'b0;
    quiet("rst_quiet", 40);

    run_div("opchange_50_5", 32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 34, 0, 3);
    tick();
    run_div("smin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 34, 0, 0);
    tick();
    run_div("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 34, 0, 0);
    tick();
    run_div("hold_1000_7", 32'd1000, 32'd7, 1'b0, {32'd6, 32'd142}, 34, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
